// File: rtl/mips_pkg.sv
// Shared constants for the instruction fetch front end.
package mips_pkg;
  localparam int          INSTR_W          = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_INC           = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; the head is read straight from registered storage.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [INSTR_W-1:0] head_instr,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty
);

  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      // Storage is cleared so the head reads zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= push_pc;
        instr_mem[wr_ptr] <= push_instr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head_pc    = pc_mem[rd_ptr];
  assign head_instr = instr_mem[rd_ptr];
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC register, imem request and prefetch FIFO towards decode.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
  parameter int                DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_a,
  input  logic [INSTR_W-1:0] imem_rd,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               misalign
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] pc;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;

  // A redirect suppresses both sides of the handshake; the FIFO is flushed anyway.
  assign pop  = instr_valid & instr_ready & ~redirect_valid;
  assign push = fetch_en & ~redirect_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= redirect_valid & (|redirect_pc[1:0]);
      if (redirect_valid)
        pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      else if (push)
        pc <= pc + ADDR_W'(PC_INC);
    end
  end

  assign imem_a      = pc;
  assign instr_valid = ~empty;

  fetch_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .flush      (redirect_valid),
    .push_pc    (pc),
    .push_instr (imem_rd),
    .head_pc    (instr_pc),
    .head_instr (instr),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: queue-level reference model plus directed literal checks.
module tb_ifetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_ready;

  logic [31:0] imem_a, imem_rd, instr, instr_pc;
  logic        instr_valid, misalign;

  // Second instance exercising the address wrap from a high reset PC.
  logic [31:0] w_imem_a, w_imem_rd, w_instr, w_instr_pc;
  logic        w_instr_valid, w_misalign;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rd   = mem_word(imem_a);
  assign w_imem_rd = mem_word(w_imem_a);

  ifetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_a(imem_a), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc), .misalign(misalign)
  );

  ifetch_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .fetch_en(1'b1), .imem_a(w_imem_a), .imem_rd(w_imem_rd),
    .redirect_valid(1'b0), .redirect_pc(32'h0), .instr_valid(w_instr_valid),
    .instr_ready(1'b1), .instr(w_instr), .instr_pc(w_instr_pc), .misalign(w_misalign)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a queue of {pc, instr}, updated from the rules at each edge.
  logic [63:0] q[$];
  logic [31:0] m_pc;
  logic        m_mis;
  bit          m_known = 0;

  always @(posedge clk) begin
    bit do_pop, do_push;
    if (reset) begin
      q.delete();
      m_pc    = 32'h0;
      m_mis   = 1'b0;
      m_known = 1;
    end else if (m_known) begin
      if (redirect_valid) begin
        q.delete();
        m_pc  = redirect_pc & 32'hFFFF_FFFC;
        m_mis = |redirect_pc[1:0];
      end else begin
        m_mis   = 1'b0;
        do_pop  = (q.size() != 0) && instr_ready;
        do_push = fetch_en && ((q.size() < 2) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("model imem_a", imem_a, m_pc);
      check("model misalign", {31'b0, misalign}, {31'b0, m_mis});
      check("model instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
      if (q.size() != 0 && instr_valid) begin
        check("model instr_pc", instr_pc, q[0][63:32]);
        check("model instr", instr, q[0][31:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1; fetch_en = 1; instr_ready = 1; redirect_valid = 0; redirect_pc = 0;
    tick(2);
    check("rst valid", {31'b0, instr_valid}, 32'd0);
    check("rst instr", instr, 32'h0);
    check("rst instr_pc", instr_pc, 32'h0);
    check("rst imem_a", imem_a, 32'h0);
    check("rst misalign", {31'b0, misalign}, 32'd0);
    check("rst wrap imem_a", w_imem_a, 32'hFFFF_FFF8);
    reset = 0;

    // Streaming, one per cycle
    tick(1);
    check("s0 valid", {31'b0, instr_valid}, 32'd1);
    check("s0 pc", instr_pc, 32'h0);
    check("s0 instr", instr, 32'h1000_0000);
    check("w0 pc", w_instr_pc, 32'hFFFF_FFF8);
    tick(1);
    check("s1 pc", instr_pc, 32'h4);
    check("s1 instr", instr, 32'h1000_0001);
    check("w1 pc", w_instr_pc, 32'hFFFF_FFFC);
    tick(1);
    check("s2 pc", instr_pc, 32'h8);
    check("s2 instr", instr, 32'h1000_0002);
    check("w2 pc", w_instr_pc, 32'h0000_0000);
    check("w2 instr", w_instr, 32'h1000_0000);

    // Backpressure: fills to two entries, pc parks after the second push
    instr_ready = 0;
    tick(5);
    check("bp head pc", instr_pc, 32'h8);
    check("bp head instr", instr, 32'h1000_0002);
    check("bp imem_a", imem_a, 32'h10);
    instr_ready = 1;
    tick(1);
    check("rel pc", instr_pc, 32'hC);
    check("rel instr", instr, 32'h1000_0003);

    // Redirect while full
    redirect_valid = 1; redirect_pc = 32'h40;
    tick(1);
    redirect_valid = 0;
    check("rd valid", {31'b0, instr_valid}, 32'd0);
    check("rd imem_a", imem_a, 32'h40);
    tick(1);
    check("rd t0 pc", instr_pc, 32'h40);
    check("rd t0 instr", instr, 32'h1000_0010);
    tick(1);
    check("rd t1 pc", instr_pc, 32'h44);
    check("rd t1 instr", instr, 32'h1000_0011);

    // Misaligned redirect
    redirect_valid = 1; redirect_pc = 32'h43;
    tick(1);
    redirect_valid = 0;
    check("mis pulse", {31'b0, misalign}, 32'd1);
    check("mis imem_a", imem_a, 32'h40);
    tick(1);
    check("mis clear", {31'b0, misalign}, 32'd0);
    check("mis head pc", instr_pc, 32'h40);

    // Fetch disabled: drains, pc frozen
    fetch_en = 0;
    tick(3);
    check("fe0 valid", {31'b0, instr_valid}, 32'd0);
    fetch_en = 1;
    tick(2);

    // Mid-run reset with FIFO full and a redirect pending
    instr_ready = 0;
    tick(2);
    reset = 1; redirect_valid = 1; redirect_pc = 32'h83;
    tick(1);
    reset = 0; redirect_valid = 0;
    check("mr valid", {31'b0, instr_valid}, 32'd0);
    check("mr imem_a", imem_a, 32'h0);
    check("mr misalign", {31'b0, misalign}, 32'd0);
    instr_ready = 1;
    tick(1);
    check("mr restart pc", instr_pc, 32'h0);
    check("mr restart instr", instr, 32'h1000_0000);

    // Mixed handshake pattern
    for (int i = 0; i < 24; i++) begin
      instr_ready = (i % 3) != 1;
      fetch_en    = (i % 7) != 5;
      tick(1);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
